// File: rtl/instr_decode_ctrl.sv
// instr_decode_ctrl: fetch/decode/control stage feeding alu_and_reg.
// A three-state sequencer (FETCH -> EXEC -> WB) accepts one 16-bit instruction
// per pass, presents registered datapath controls for exactly the EXEC cycle,
// advances the PC (including conditional branches), and captures ALU flags
// into the psr during WB.
//
// Handshake: an instruction is transferred on a rising edge where instr_valid
// and instr_ready are both 1. instr_ready is 1 only in FETCH while run is 1.
// The source must hold instr stable while instr_valid is 1 and not yet
// accepted.
module instr_decode_ctrl #(
    parameter int                  PC_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
    parameter logic [4:0]          NOREG    = 5'd16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                run,
    input  logic [15:0]         instr,
    input  logic                instr_valid,
    output logic                instr_ready,
    output logic [PC_WIDTH-1:0] pc,
    input  logic [4:0]          flags,
    output logic [7:0]          aluOp,
    output logic [4:0]          RegEn,
    output logic [4:0]          BufEnA,
    output logic [4:0]          BufEnB,
    output logic [15:0]         imm,
    output logic                immEn,
    output logic                cin,
    output logic [4:0]          psr,
    output logic                retire,
    output logic                illegal
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_WB    = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [15:0]         ir_q;
    logic                upd_q;
    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [4:0]          psr_q, psr_d;
    logic                accept;
    logic                taken;

    // Decoded controls for the instruction currently on the instr bus
    logic [7:0]  dec_aluop;
    logic [4:0]  dec_regen, dec_bufa, dec_bufb;
    logic [15:0] dec_imm;
    logic        dec_immen, dec_cin, dec_ill, dec_upd;

    assign accept = instr_valid && instr_ready;
    assign pc     = pc_q;
    assign psr    = psr_q;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic: fixed three-cycle walk once an instruction is taken
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (accept) state_d = S_EXEC;
            S_EXEC:  state_d = S_WB;
            S_WB:    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // FSM outputs: fetching is allowed only in FETCH with run asserted
    always_comb begin
        instr_ready = (state_q == S_FETCH) && run;
    end

    // Instruction decode; anything undecodable leaves the datapath idle
    always_comb begin
        dec_aluop = 8'h00;
        dec_regen = NOREG;
        dec_bufa  = NOREG;
        dec_bufb  = NOREG;
        dec_imm   = 16'h0000;
        dec_immen = 1'b0;
        dec_cin   = 1'b0;
        dec_ill   = 1'b0;
        dec_upd   = 1'b0;
        case (instr[15:12])
            4'h0: begin
                case (instr[7:4])
                    4'h1, 4'h2, 4'h3, 4'h5, 4'h9: begin
                        dec_aluop = {4'h0, instr[7:4]};
                        dec_bufa  = {1'b0, instr[11:8]};
                        dec_bufb  = {1'b0, instr[3:0]};
                        dec_regen = {1'b0, instr[11:8]};
                        dec_upd   = 1'b1;
                    end
                    4'hB: begin
                        dec_aluop = 8'h0B;
                        dec_bufa  = {1'b0, instr[11:8]};
                        dec_bufb  = {1'b0, instr[3:0]};
                        dec_upd   = 1'b1;
                    end
                    4'h6: begin
                        dec_aluop = 8'h05;
                        dec_bufa  = {1'b0, instr[11:8]};
                        dec_bufb  = {1'b0, instr[3:0]};
                        dec_regen = {1'b0, instr[11:8]};
                        dec_cin   = psr_q[4];
                        dec_upd   = 1'b1;
                    end
                    4'hD: begin
                        dec_aluop = 8'h05;
                        dec_bufb  = {1'b0, instr[3:0]};
                        dec_regen = {1'b0, instr[11:8]};
                    end
                    default: dec_ill = 1'b1;
                endcase
            end
            4'h1, 4'h2, 4'h3, 4'h5, 4'h9, 4'hB: begin
                dec_aluop = {4'h0, instr[15:12]};
                dec_bufa  = {1'b0, instr[11:8]};
                dec_immen = 1'b1;
                dec_upd   = 1'b1;
                if (instr[15:12] != 4'hB) dec_regen = {1'b0, instr[11:8]};
                // Logical ops take a zero-extended mask, arithmetic a signed value
                if (instr[15:12] == 4'h1 || instr[15:12] == 4'h2 || instr[15:12] == 4'h3)
                    dec_imm = {8'h00, instr[7:0]};
                else
                    dec_imm = {{8{instr[7]}}, instr[7:0]};
            end
            4'hD: begin
                dec_aluop = 8'h05;
                dec_immen = 1'b1;
                dec_imm   = {{8{instr[7]}}, instr[7:0]};
                dec_regen = {1'b0, instr[11:8]};
            end
            4'hC: ; // branch: no datapath activity, resolved in EXEC
            default: dec_ill = 1'b1;
        endcase
    end

    // Branch condition evaluated against the psr held during EXEC
    always_comb begin
        taken = 1'b0;
        if (ir_q[15:12] == 4'hC) begin
            case (ir_q[11:8])
                4'h0: taken = psr_q[1];
                4'h1: taken = !psr_q[1];
                4'h2: taken = psr_q[4];
                4'h3: taken = !psr_q[4];
                4'h4: taken = psr_q[2];
                4'h5: taken = !psr_q[2];
                4'h6: taken = psr_q[0];
                4'h7: taken = !psr_q[0];
                4'h8: taken = 1'b1;
                default: taken = 1'b0;
            endcase
        end
    end

    // Next PC and psr: pc moves on the EXEC closing edge, psr on the WB closing edge
    always_comb begin
        pc_d  = pc_q;
        psr_d = psr_q;
        if (state_q == S_EXEC)
            pc_d = taken ? pc_q + {{(PC_WIDTH-8){ir_q[7]}}, ir_q[7:0]}
                         : pc_q + {{(PC_WIDTH-1){1'b0}}, 1'b1};
        if (state_q == S_WB && upd_q)
            psr_d = flags;
    end

    // Architectural state and registered controls; controls are live only in EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q    <= RESET_PC;
            psr_q   <= 5'b00000;
            ir_q    <= 16'h0000;
            upd_q   <= 1'b0;
            aluOp   <= 8'h00;
            RegEn   <= NOREG;
            BufEnA  <= NOREG;
            BufEnB  <= NOREG;
            imm     <= 16'h0000;
            immEn   <= 1'b0;
            cin     <= 1'b0;
            retire  <= 1'b0;
            illegal <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            psr_q   <= psr_d;
            retire  <= (state_q == S_EXEC);
            illegal <= accept && dec_ill;
            if (accept) begin
                ir_q  <= instr;
                upd_q <= dec_upd;
            end
            aluOp  <= accept ? dec_aluop : 8'h00;
            RegEn  <= accept ? dec_regen : NOREG;
            BufEnA <= accept ? dec_bufa  : NOREG;
            BufEnB <= accept ? dec_bufb  : NOREG;
            imm    <= accept ? dec_imm   : 16'h0000;
            immEn  <= accept ? dec_immen : 1'b0;
            cin    <= accept ? dec_cin   : 1'b0;
        end
    end

endmodule

// File: tb/tb_instr_decode_ctrl.sv
// tb_instr_decode_ctrl: directed checks of the fetch/decode/control stage.
module tb_instr_decode_ctrl;

    logic        clk = 1'b0;
    logic        reset, run, instr_valid, instr_ready;
    logic [15:0] instr, pc, imm;
    logic [4:0]  flags, RegEn, BufEnA, BufEnB, psr;
    logic [7:0]  aluOp;
    logic        immEn, cin, retire, illegal;

    int n_cmp = 0;
    int n_err = 0;

    instr_decode_ctrl dut (
        .clk(clk), .reset(reset), .run(run), .instr(instr),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .pc(pc),
        .flags(flags), .aluOp(aluOp), .RegEn(RegEn), .BufEnA(BufEnA),
        .BufEnB(BufEnB), .imm(imm), .immEn(immEn), .cin(cin), .psr(psr),
        .retire(retire), .illegal(illegal)
    );

    // Clock
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present w, check it is accepted, return #1 after the accepting edge (EXEC)
    task automatic issue(input logic [15:0] w);
        @(negedge clk);
        instr       = w;
        instr_valid = 1'b1;
        chk("ready_before_accept", instr_ready, 1'b1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Idle control values expected outside EXEC
    task automatic chk_idle(input string tag);
        chk({tag, "_regen"}, RegEn, 5'd16);
        chk({tag, "_bufa"}, BufEnA, 5'd16);
        chk({tag, "_bufb"}, BufEnB, 5'd16);
        chk({tag, "_aluop"}, aluOp, 8'h00);
        chk({tag, "_immen"}, immEn, 1'b0);
        chk({tag, "_imm"}, imm, 16'h0000);
    endtask

    initial begin
        reset = 1'b1; run = 1'b0; instr_valid = 1'b0; instr = 16'h0000; flags = 5'b00000;
        #12;
        chk("rst_pc", pc, 16'h0000);
        chk("rst_psr", psr, 5'b00000);
        chk("rst_retire", retire, 1'b0);
        chk("rst_illegal", illegal, 1'b0);
        chk("rst_cin", cin, 1'b0);
        chk_idle("rst");
        @(negedge clk); reset = 1'b0; run = 1'b1;

        // ADDI R0,#12
        issue(16'h5012);
        chk("t1_aluop", aluOp, 8'h05); chk("t1_regen", RegEn, 5'd0);
        chk("t1_bufa", BufEnA, 5'd0); chk("t1_bufb", BufEnB, 5'd16);
        chk("t1_immen", immEn, 1'b1); chk("t1_imm", imm, 16'h0012);
        chk("t1_pc_exec", pc, 16'h0000); chk("t1_retire_exec", retire, 1'b0);
        step();
        chk("t1_pc_wb", pc, 16'h0001); chk("t1_retire_wb", retire, 1'b1);
        chk_idle("t1_wb");
        step();
        chk("t1_retire_fetch", retire, 1'b0); chk("t1_psr", psr, 5'b00000);

        // SUBI sign-extends, ANDI zero-extends
        issue(16'h91FF);
        chk("t2a_aluop", aluOp, 8'h09); chk("t2a_imm", imm, 16'hFFFF); chk("t2a_regen", RegEn, 5'd1);
        step(); step();
        issue(16'h11FF);
        chk("t2b_aluop", aluOp, 8'h01); chk("t2b_imm", imm, 16'h00FF);
        step(); step();
        chk("t2_pc", pc, 16'h0003);

        // ADD R2,R1 then CMP R2,R1
        issue(16'h0251);
        chk("t3a_aluop", aluOp, 8'h05); chk("t3a_bufa", BufEnA, 5'd2);
        chk("t3a_bufb", BufEnB, 5'd1); chk("t3a_regen", RegEn, 5'd2); chk("t3a_immen", immEn, 1'b0);
        step(); step();
        flags = 5'b00010;
        issue(16'h02B1);
        chk("t3b_aluop", aluOp, 8'h0B); chk("t3b_regen", RegEn, 5'd16);
        chk("t3b_bufa", BufEnA, 5'd2); chk("t3b_bufb", BufEnB, 5'd1);
        step(); step();
        chk("t3b_psr", psr, 5'b00010); chk("t3b_pc", pc, 16'h0005);

        // BEQ -2 taken (Z=1), psr unchanged despite new flags
        flags = 5'b01000;
        issue(16'hC0FE);
        chk("t4a_regen", RegEn, 5'd16); chk("t4a_aluop", aluOp, 8'h00);
        step();
        chk("t4a_pc", pc, 16'h0003);
        step();
        chk("t4a_psr", psr, 5'b00010);

        // CMPI clears Z, MOV leaves psr alone, then BEQ not taken
        flags = 5'b00000;
        issue(16'hB000);
        chk("t4b_regen", RegEn, 5'd16); chk("t4b_immen", immEn, 1'b1); chk("t4b_aluop", aluOp, 8'h0B);
        step(); step();
        chk("t4b_psr", psr, 5'b00000);
        flags = 5'b11111;
        issue(16'h0AD3);
        chk("mov_aluop", aluOp, 8'h05); chk("mov_bufa", BufEnA, 5'd16);
        chk("mov_bufb", BufEnB, 5'd3); chk("mov_regen", RegEn, 5'd10);
        step(); step();
        chk("mov_psr", psr, 5'b00000); chk("mov_pc", pc, 16'h0005);
        issue(16'hC0FE);
        step();
        chk("t4c_pc", pc, 16'h0006);
        step();

        // ADDC picks up carry from psr
        flags = 5'b10000;
        issue(16'hB000);
        step(); step();
        chk("addc_psr_c", psr, 5'b10000);
        flags = 5'b00000;
        issue(16'h0165);
        chk("addc_aluop", aluOp, 8'h05); chk("addc_cin", cin, 1'b1);
        chk("addc_bufa", BufEnA, 5'd1); chk("addc_bufb", BufEnB, 5'd5); chk("addc_regen", RegEn, 5'd1);
        step();
        chk("addc_cin_wb", cin, 1'b0);
        step();
        chk("addc_psr", psr, 5'b00000);

        // MOVI R3,#-1 with flags that must not be captured
        flags = 5'b11111;
        issue(16'hD3FF);
        chk("movi_aluop", aluOp, 8'h05); chk("movi_bufa", BufEnA, 5'd16);
        chk("movi_imm", imm, 16'hFFFF); chk("movi_immen", immEn, 1'b1); chk("movi_regen", RegEn, 5'd3);
        step(); step();
        chk("movi_psr", psr, 5'b00000); chk("movi_pc", pc, 16'h0009);

        // run=0 blocks fetch even with a valid instruction offered
        @(negedge clk);
        run = 1'b0; instr = 16'h5012; instr_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_ready", instr_ready, 1'b0); chk("hold_pc", pc, 16'h0009);
            chk("hold_psr", psr, 5'b00000); chk("hold_regen", RegEn, 5'd16);
            chk("hold_retire", retire, 1'b0);
        end
        instr_valid = 1'b0; run = 1'b1;

        // Undefined opcode
        issue(16'h7000);
        chk("ill_pulse", illegal, 1'b1); chk("ill_regen", RegEn, 5'd16); chk("ill_aluop", aluOp, 8'h00);
        step();
        chk("ill_clear", illegal, 1'b0); chk("ill_pc", pc, 16'h000A); chk("ill_retire", retire, 1'b1);
        step();
        chk("ill_psr", psr, 5'b00000);

        // Condition 9 never branches
        issue(16'hC905);
        step();
        chk("never_pc", pc, 16'h000B);
        step();

        // run drops during EXEC: instruction still completes, then no fetch
        issue(16'h5012);
        run = 1'b0;
        step();
        chk("rundrop_retire", retire, 1'b1); chk("rundrop_pc", pc, 16'h000C);
        step();
        chk("rundrop_ready", instr_ready, 1'b0);
        run = 1'b1;

        // Async reset in EXEC abandons the instruction immediately
        issue(16'h5012);
        chk("prerst_regen", RegEn, 5'd0);
        #2 reset = 1'b1;
        #1;
        chk("midrst_regen", RegEn, 5'd16); chk("midrst_pc", pc, 16'h0000);
        chk("midrst_aluop", aluOp, 8'h00); chk("midrst_immen", immEn, 1'b0);
        #1 reset = 1'b0;

        // Unconditional branch backwards from 0 wraps
        issue(16'hC880);
        step();
        chk("wrap_pc", pc, 16'hFF80);
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #50000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
